// File: rtl/operand_entry.sv
// operand_entry: debounced, auto-repeating hex operand entry.
// Each of four push-buttons steps one nibble of a 16-bit word up or down,
// with the direction taken from a matching switch.
// Everything runs on clk; the buttons are only ever sampled as data.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   btn   - raw push-buttons, active-high; btn[i] steps nibble i
//   sw    - raw direction switches; 1 = decrement, 0 = increment
//   num   - registered operand word (num[3:0] is nibble 0)
//   step  - registered one-cycle pulse per nibble, high while it takes its new value
module operand_entry #(
  parameter logic [15:0] INIT_HEXES  = 16'hABCD,
  parameter int unsigned TICK_CYCLES = 131072,
  parameter int unsigned DB_LEN      = 8,
  parameter int unsigned HOLD_TICKS  = 64,
  parameter int unsigned RPT_TICKS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic [3:0]  sw,
  output logic [15:0] num,
  output logic [3:0]  step
);

  localparam int unsigned N_BTN  = 4;
  localparam int unsigned TC_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned RC_MAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  // rc only ever holds 0..RC_MAX-1
  localparam int unsigned RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RPT  = 2'd2;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for buttons and switches
  // ---------------------------------------------------------------------------
  logic [3:0] btn_meta;
  logic [3:0] bs;
  logic [3:0] sw_meta;
  logic [3:0] ss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= '0;
      bs       <= '0;
      sw_meta  <= '0;
      ss       <= '0;
    end else begin
      btn_meta <= btn;
      bs       <= btn_meta;
      sw_meta  <= sw;
      ss       <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-tick prescaler
  // ---------------------------------------------------------------------------
  logic [TC_W-1:0] tc;
  logic            tick_c;

  assign tick_c = (tc == TC_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc <= '0;
    end else if (tick_c) begin
      tc <= '0;
    end else begin
      tc <= tc + TC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: db changes only after DB_LEN equal tick samples
  // ---------------------------------------------------------------------------
  logic [DB_LEN-1:0] sr     [N_BTN];
  logic [DB_LEN-1:0] sr_nxt [N_BTN];
  logic [3:0]        db;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      sr_nxt[i] = {sr[i][DB_LEN-2:0], bs[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        sr[i] <= '0;
      end
      db <= '0;
    end else if (tick_c) begin
      for (int i = 0; i < N_BTN; i++) begin
        sr[i] <= sr_nxt[i];
        if (&sr_nxt[i]) begin
          db[i] <= 1'b1;
        end else if (~|sr_nxt[i]) begin
          db[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button repeat FSM: state and tick counter registers
  // ---------------------------------------------------------------------------
  logic [1:0]      state     [N_BTN];
  logic [1:0]      state_nxt [N_BTN];
  logic [RC_W-1:0] rc        [N_BTN];
  logic [RC_W-1:0] rc_nxt    [N_BTN];
  logic [3:0]      step_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= S_IDLE;
        rc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= state_nxt[i];
        rc[i]    <= rc_nxt[i];
      end
    end
  end

  // Next-state and step decode; a released button wins over a same-cycle tick
  always_comb begin
    step_c = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_nxt[i] = state[i];
      rc_nxt[i]    = rc[i];
      case (state[i])
        S_IDLE: begin
          if (db[i]) begin
            step_c[i]    = 1'b1;
            rc_nxt[i]    = '0;
            state_nxt[i] = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!db[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (tick_c) begin
            if (rc[i] == RC_W'(HOLD_TICKS - 1)) begin
              step_c[i]    = 1'b1;
              rc_nxt[i]    = '0;
              state_nxt[i] = S_RPT;
            end else begin
              rc_nxt[i] = rc[i] + RC_W'(1);
            end
          end
        end
        S_RPT: begin
          if (!db[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (tick_c) begin
            if (rc[i] == RC_W'(RPT_TICKS - 1)) begin
              step_c[i] = 1'b1;
              rc_nxt[i] = '0;
            end else begin
              rc_nxt[i] = rc[i] + RC_W'(1);
            end
          end
        end
        default: begin
          state_nxt[i] = S_IDLE;
          rc_nxt[i]    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand register: each stepped nibble moves by one, modulo 16
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num  <= INIT_HEXES;
      step <= '0;
    end else begin
      step <= step_c;
      for (int i = 0; i < N_BTN; i++) begin
        if (step_c[i]) begin
          num[4*i +: 4] <= ss[i] ? (num[4*i +: 4] - 4'd1) : (num[4*i +: 4] + 4'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed scenarios plus randomized button/switch traffic,
// compared every cycle against a behavioural model of the entry rules.
module tb_operand_entry;

  localparam int unsigned TICK = 4;
  localparam int unsigned DBL  = 3;
  localparam int unsigned HOLD = 3;
  localparam int unsigned RPT  = 2;
  localparam logic [15:0] INIT = 16'hABCD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic [3:0]  sw  = 4'b0000;
  logic [15:0] num;
  logic [3:0]  step;

  int n_checks = 0;
  int n_errors = 0;

  operand_entry #(
    .INIT_HEXES (INIT),
    .TICK_CYCLES(TICK),
    .DB_LEN     (DBL),
    .HOLD_TICKS (HOLD),
    .RPT_TICKS  (RPT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .sw  (sw),
    .num (num),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: synchronizer delay, tick sampling, "DB_LEN equal
  // samples in a row" debounce, and step times counted in ticks since press.
  logic [3:0]  m_b1, m_bs, m_s1, m_ss, m_db;
  int          m_cnt;
  int          run_len [4];
  bit          run_val [4];
  bit          started [4];
  int          t_since [4];
  logic [15:0] exp_num;
  logic [3:0]  exp_step;
  logic [3:0]  nstep;
  bit          tick_now;
  logic [3:0]  nib;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_b1 = '0; m_bs = '0; m_s1 = '0; m_ss = '0; m_db = '0;
      m_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        run_len[i] = DBL; run_val[i] = 1'b0; started[i] = 1'b0; t_since[i] = 0;
      end
      exp_num  = INIT;
      exp_step = '0;
    end else begin
      tick_now = (m_cnt == TICK - 1);
      nstep = '0;
      for (int i = 0; i < 4; i++) begin
        if (!m_db[i]) begin
          started[i] = 1'b0;
        end else if (!started[i]) begin
          nstep[i] = 1'b1; started[i] = 1'b1; t_since[i] = 0;
        end else if (tick_now) begin
          t_since[i]++;
          if (t_since[i] == HOLD || (t_since[i] > HOLD && (t_since[i] - HOLD) % RPT == 0))
            nstep[i] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (nstep[i]) begin
          nib = exp_num[4*i +: 4];
          exp_num[4*i +: 4] = m_ss[i] ? nib - 4'd1 : nib + 4'd1;
        end
      end
      exp_step = nstep;
      if (tick_now) begin
        for (int i = 0; i < 4; i++) begin
          if (m_bs[i] == run_val[i]) begin
            if (run_len[i] < DBL) run_len[i]++;
          end else begin
            run_val[i] = m_bs[i]; run_len[i] = 1;
          end
          if (run_len[i] >= DBL) m_db[i] = run_val[i];
        end
      end
      m_cnt = tick_now ? 0 : m_cnt + 1;
      m_bs = m_b1; m_b1 = btn;
      m_ss = m_s1; m_s1 = sw;
    end
  end

  // Per-cycle comparison plus pulse bookkeeping for the scenario checks
  bit          chk_en = 1'b0;
  int          obs_cnt [4];
  int          exp_cnt [4];
  bit          saw_both, saw_wrap_dn, saw_wrap_up;
  logic [15:0] prev_num = INIT;

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("num", num, exp_num);
      check("step", step, exp_step);
      for (int i = 0; i < 4; i++) begin
        obs_cnt[i] += int'(step[i]);
        exp_cnt[i] += int'(exp_step[i]);
      end
      if (step == 4'b0011) saw_both = 1'b1;
      if (step[1] && prev_num[7:4] == 4'h0 && num[7:4] == 4'hF) saw_wrap_dn = 1'b1;
      if (step[1] && prev_num[7:4] == 4'hF && num[7:4] == 4'h0) saw_wrap_up = 1'b1;
    end
    prev_num = num;
  end

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      obs_cnt[i] = 0; exp_cnt[i] = 0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] s, input int n);
    btn = b; sw = s;
    cycles(n);
    btn = 4'b0000;
  endtask

  task automatic settle();
    btn = 4'b0000;
    cycles(10 * TICK);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_num", num, INIT);
    check("async_rst_step", step, 4'b0000);
    rst = 1'b1;
  endtask

  logic [15:0] snap;
  int          ticks;
  int          len;

  initial begin
    clear_counts();
    // 1: reset values, then a press on nibble 0
    cycles(3);
    check("rst_num", num, INIT);
    check("rst_step", step, 4'b0000);
    rst = 1'b1;
    chk_en = 1'b1;
    clear_counts();
    press(4'b0001, 4'b0000, 4 * TICK);
    settle();
    check("t1_pulses0", obs_cnt[0], exp_cnt[0]);
    check("t1_stepped", int'(obs_cnt[0] > 0), 1);
    check("t1_num", num, exp_num);

    // 2: decrement through 0->F, then increment through F->0, on nibble 1
    snap = exp_num;
    saw_wrap_dn = 1'b0; saw_wrap_up = 1'b0;
    press(4'b0010, 4'b0010, 30 * TICK);
    settle();
    check("t2_wrap_dn", saw_wrap_dn, 1'b1);
    press(4'b0010, 4'b0000, 30 * TICK);
    settle();
    check("t2_wrap_up", saw_wrap_up, 1'b1);
    check("t2_others", {num[15:8], num[3:0]}, {snap[15:8], snap[3:0]});

    // 3: bounce shorter than DB_LEN ticks on button 2
    clear_counts();
    snap = exp_num;
    ticks = 0;
    while (ticks < 40) begin
      len = $urandom_range(1, DBL - 1);
      btn = 4'b0100; cycles(len * TICK); ticks += len;
      len = $urandom_range(1, DBL - 1);
      btn = 4'b0000; cycles(len * TICK); ticks += len;
    end
    settle();
    check("t3_pulses2", obs_cnt[2], 0);
    check("t3_num", num, snap);

    // 4: auto-repeat on nibble 3, then silence after release
    clear_counts();
    press(4'b1000, 4'b0000, (DBL + 12) * TICK);
    settle();
    check("t4_pulses3", obs_cnt[3], exp_cnt[3]);
    check("t4_repeated", int'(obs_cnt[3] >= 6), 1);
    clear_counts();
    cycles(10 * TICK);
    check("t4_quiet", obs_cnt[3], 0);

    // 5: simultaneous presses on nibbles 0 and 1
    clear_counts();
    saw_both = 1'b0;
    press(4'b0011, 4'b0010, DBL * TICK);
    settle();
    check("t5_both", saw_both, 1'b1);
    check("t5_pulses0", obs_cnt[0], exp_cnt[0]);
    check("t5_pulses1", obs_cnt[1], exp_cnt[1]);

    // 6: asynchronous reset while repeating; held button must re-debounce
    btn = 4'b1000; sw = 4'b0000;
    cycles((DBL + 8) * TICK);
    pulse_reset();
    clear_counts();
    cycles(2 * TICK);
    check("t6_no_early_step", obs_cnt[3], 0);
    cycles(4 * TICK);
    check("t6_restep", int'(obs_cnt[3] > 0), 1);
    settle();

    // Randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 150; k++) begin
      btn = 4'($urandom);
      sw  = 4'($urandom);
      cycles($urandom_range(1, 6 * TICK));
      if ($urandom_range(0, 24) == 0) pulse_reset();
    end
    settle();
    check("final_num", num, exp_num);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
